// File: rtl/mag_comparator_pkg.sv
// Shared types for the registered magnitude comparator.
// Holds the compare-result encoding and the default operand width.
package cmp_pkg;
  localparam int DEFAULT_N = 4;

  typedef enum logic [1:0] {CMP_EQ, CMP_LT, CMP_GT} cmp_res_t;
endpackage

// File: rtl/mag_comparator_if.sv
// Operand/result bundle for mag_comparator.
// The master drives operands and reads results; the slave side is the comparator.
interface mag_comparator_if #(parameter int N = cmp_pkg::DEFAULT_N);
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         in_valid;
  logic         signed_mode;
  logic         A_gt_B;
  logic         A_lt_B;
  logic         A_eq_B;
  logic [N-1:0] max_val;
  logic [N-1:0] min_val;
  logic         out_valid;

  modport master (
    output A, B, in_valid, signed_mode,
    input  A_gt_B, A_lt_B, A_eq_B, max_val, min_val, out_valid
  );

  modport slave (
    input  A, B, in_valid, signed_mode,
    output A_gt_B, A_lt_B, A_eq_B, max_val, min_val, out_valid
  );
endinterface

// File: rtl/mag_compare_core.sv
// Combinational N-bit compare. Signed ordering is obtained by flipping
// both sign bits, which maps two's-complement order onto unsigned order.
module mag_compare_core
  import cmp_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_signed_mode,
  output cmp_res_t     o_res
);
  logic [N-1:0] w_msb_flip;
  logic [N-1:0] w_a;
  logic [N-1:0] w_b;

  always_comb begin
    w_msb_flip        = '0;
    w_msb_flip[N-1]   = i_signed_mode;
  end

  assign w_a = i_a ^ w_msb_flip;
  assign w_b = i_b ^ w_msb_flip;

  always_comb begin
    o_res = CMP_EQ;
    if (w_a < w_b)      o_res = CMP_LT;
    else if (w_a > w_b) o_res = CMP_GT;
  end
endmodule

// File: rtl/mag_comparator.sv
// Registered magnitude comparator: one-cycle latency, one compare per cycle.
// Flags and max/min hold their last values while no fresh input arrives.
module mag_comparator
  import cmp_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic clk,
  input  logic rst_n,
  mag_comparator_if.slave bus
);
  cmp_res_t     w_res;
  logic         r_gt;
  logic         r_lt;
  logic         r_eq;
  logic         r_vld;
  logic [N-1:0] r_max;
  logic [N-1:0] r_min;

  mag_compare_core #(.N(N)) u_core (
    .i_a           (bus.A),
    .i_b           (bus.B),
    .i_signed_mode (bus.signed_mode),
    .o_res         (w_res)
  );

  // On equality max takes A and min takes B, so only LT swaps the operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gt  <= 1'b0;
      r_lt  <= 1'b0;
      r_eq  <= 1'b0;
      r_vld <= 1'b0;
      r_max <= '0;
      r_min <= '0;
    end else begin
      r_vld <= bus.in_valid;
      if (bus.in_valid) begin
        r_gt  <= (w_res == CMP_GT);
        r_lt  <= (w_res == CMP_LT);
        r_eq  <= (w_res == CMP_EQ);
        r_max <= (w_res == CMP_LT) ? bus.B : bus.A;
        r_min <= (w_res == CMP_LT) ? bus.A : bus.B;
      end
    end
  end

  assign bus.A_gt_B    = r_gt;
  assign bus.A_lt_B    = r_lt;
  assign bus.A_eq_B    = r_eq;
  assign bus.max_val   = r_max;
  assign bus.min_val   = r_min;
  assign bus.out_valid = r_vld;
endmodule

// File: tb/tb_mag_comparator.sv
// Scoreboard bench for mag_comparator (N=4): stimulus pushes hand-computed
// results, a negedge monitor pops them whenever out_valid is seen.
module tb_mag_comparator;
  localparam int N  = 4;
  localparam int NV = 9;
  localparam int RW = 3 + 2 * N;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mag_comparator_if #(.N(N)) bus ();

  mag_comparator #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector table: a, b, signed, expected {gt,lt,eq}, max, min.
  logic [N-1:0] va   [NV] = '{4'b0011, 4'b1001, 4'b1001, 4'b0101, 4'b0101,
                              4'b1111, 4'b1000, 4'b1111, 4'b1000};
  logic [N-1:0] vb   [NV] = '{4'b0100, 4'b0110, 4'b0110, 4'b0101, 4'b0101,
                              4'b0000, 4'b0111, 4'b0000, 4'b0111};
  logic         vs   [NV] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                              1'b0, 1'b1, 1'b1, 1'b0};
  logic [2:0]   vflg [NV] = '{3'b010, 3'b100, 3'b010, 3'b001, 3'b001,
                              3'b100, 3'b010, 3'b010, 3'b100};
  logic [N-1:0] vmax [NV] = '{4'b0100, 4'b1001, 4'b0110, 4'b0101, 4'b0101,
                              4'b1111, 4'b0111, 4'b0000, 4'b1000};
  logic [N-1:0] vmin [NV] = '{4'b0011, 4'b0110, 4'b1001, 4'b0101, 4'b0101,
                              4'b0000, 4'b1000, 4'b1111, 4'b0111};

  logic [RW-1:0] sb_q[$];
  logic [RW-1:0] last_exp;

  task automatic chk(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got gt/lt/eq=%b max=%b min=%b, want gt/lt/eq=%b max=%b min=%b",
               name, got[RW-1 -: 3], got[2*N-1 -: N], got[N-1:0],
               exp[RW-1 -: 3], exp[2*N-1 -: N], exp[N-1:0]);
    end
  endtask

  function automatic logic [RW-1:0] dut_res();
    return {bus.A_gt_B, bus.A_lt_B, bus.A_eq_B, bus.max_val, bus.min_val};
  endfunction

  // Monitor: fresh results are popped in order; idle cycles must hold.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got out_valid=1, want no pending result");
        end else begin
          last_exp = sb_q.pop_front();
          chk("result", dut_res(), last_exp);
        end
      end else begin
        total++;
        if (bus.out_valid !== 1'b0) begin
          bad++;
          $display("FAIL out_valid_x: got %b want 0", bus.out_valid);
        end
        chk("hold", dut_res(), last_exp);
      end
    end
  end

  task automatic send(input int i);
    @(posedge clk);
    #1;
    bus.A           = va[i];
    bus.B           = vb[i];
    bus.signed_mode = vs[i];
    bus.in_valid    = 1'b1;
    sb_q.push_back({vflg[i], vmax[i], vmin[i]});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, dut_res(), '0);
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_valid: got out_valid=%b want 0", name, bus.out_valid);
    end
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    last_exp        = '0;
    rst_n           = 1'b0;
    bus.A           = '0;
    bus.B           = '0;
    bus.signed_mode = 1'b0;
    bus.in_valid    = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Isolated transactions, each followed by an idle cycle.
    for (int i = 0; i < NV; i++) begin
      send(i);
      idle(1);
    end
    idle(1);

    // Back-to-back stream, then in_valid drops and results must hold.
    for (int i = 0; i < NV; i++) send(i);
    idle(3);

    // Reset mid-stream while a result is being presented.
    send(0);
    send(1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    last_exp = '0;
    #1;
    chk_zero("async_reset");
    repeat (2) @(negedge clk);
    #2;
    chk_zero("reset_held");
    rst_n = 1'b1;

    send(2);
    idle(3);

    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending results want 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
